// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register of the rv32i core.
// Captures M-stage control and data, extracts and extends load data, and
// drives the writeback result mux and the register-file write port.
// Optional feature macro: MEMWB_RETIRE_CNT_EN (retired-instruction counter).
module mem_wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              ValidM_i,
  input  logic              RegWriteM_i,
  input  logic [1:0]        ResultSrcM_i,
  input  logic [2:0]        Funct3M_i,
  input  logic [XLEN-1:0]   ALUResultM_i,
  input  logic [XLEN-1:0]   ReadDataM_i,
  input  logic [4:0]        RdM_i,
  input  logic [XLEN-1:0]   PCPlus4M_i,
  input  logic              StallW_i,
  input  logic              FlushW_i,
  output logic              ValidW_o,
  output logic              RegWriteW_o,
  output logic [4:0]        RdW_o,
  output logic [XLEN-1:0]   ResultW_o,
  output logic              MisalignW_o,
  output logic [CNT_W-1:0]  RetireCountW_o
);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_LOAD = 2'b01;
  localparam logic [1:0] SRC_PC4  = 2'b10;

  logic            valid_q,      valid_d;
  logic            regwrite_q,   regwrite_d;
  logic [4:0]      rd_q,         rd_d;
  logic [1:0]      result_src_q, result_src_d;
  logic [XLEN-1:0] alu_result_q, alu_result_d;
  logic [XLEN-1:0] load_data_q,  load_data_d;
  logic [XLEN-1:0] pc_plus4_q,   pc_plus4_d;
  logic            misalign_q,   misalign_d;

  logic [1:0]      addr_lo;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_ext;
  logic            misalign_raw;
  logic            misalign_m;
  logic [XLEN-1:0] load_data_m;

  assign addr_lo = ALUResultM_i[1:0];

  // Load extraction and misalignment detection from the raw M-stage word.
  always_comb begin
    byte_sel     = ReadDataM_i[7:0];
    half_sel     = addr_lo[1] ? ReadDataM_i[31:16] : ReadDataM_i[15:0];
    load_ext     = ReadDataM_i;
    misalign_raw = 1'b0;
    case (addr_lo)
      2'd0:    byte_sel = ReadDataM_i[7:0];
      2'd1:    byte_sel = ReadDataM_i[15:8];
      2'd2:    byte_sel = ReadDataM_i[23:16];
      default: byte_sel = ReadDataM_i[31:24];
    endcase
    case (Funct3M_i)
      F3_LB:  load_ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU: load_ext = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH: begin
        load_ext     = {{(XLEN-16){half_sel[15]}}, half_sel};
        misalign_raw = addr_lo[0];
      end
      F3_LHU: begin
        load_ext     = {{(XLEN-16){1'b0}}, half_sel};
        misalign_raw = addr_lo[0];
      end
      F3_LW: begin
        load_ext     = ReadDataM_i;
        misalign_raw = (addr_lo != 2'b00);
      end
      default: load_ext = ReadDataM_i;
    endcase
    // The misalign flag only matters for a real instruction selecting load data.
    misalign_m  = misalign_raw & ValidM_i & (ResultSrcM_i == SRC_LOAD);
    load_data_m = misalign_m ? '0 : load_ext;
  end

  // Next-state selection: flush beats stall beats a normal capture.
  always_comb begin
    valid_d      = valid_q;
    regwrite_d   = regwrite_q;
    rd_d         = rd_q;
    result_src_d = result_src_q;
    alu_result_d = alu_result_q;
    load_data_d  = load_data_q;
    pc_plus4_d   = pc_plus4_q;
    misalign_d   = misalign_q;
    if (FlushW_i) begin
      valid_d      = 1'b0;
      regwrite_d   = 1'b0;
      rd_d         = '0;
      result_src_d = '0;
      alu_result_d = '0;
      load_data_d  = '0;
      pc_plus4_d   = '0;
      misalign_d   = 1'b0;
    end else if (!StallW_i) begin
      valid_d      = ValidM_i;
      regwrite_d   = RegWriteM_i & ValidM_i & ~misalign_m;
      rd_d         = RdM_i;
      result_src_d = ResultSrcM_i;
      alu_result_d = ALUResultM_i;
      load_data_d  = load_data_m;
      pc_plus4_d   = PCPlus4M_i;
      misalign_d   = misalign_m;
    end
  end

  // W-stage register bank with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q      <= 1'b0;
      regwrite_q   <= 1'b0;
      rd_q         <= '0;
      result_src_q <= '0;
      alu_result_q <= '0;
      load_data_q  <= '0;
      pc_plus4_q   <= '0;
      misalign_q   <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      regwrite_q   <= regwrite_d;
      rd_q         <= rd_d;
      result_src_q <= result_src_d;
      alu_result_q <= alu_result_d;
      load_data_q  <= load_data_d;
      pc_plus4_q   <= pc_plus4_d;
      misalign_q   <= misalign_d;
    end
  end

  // Writeback result mux; the reserved encoding yields zero.
  always_comb begin
    ResultW_o = '0;
    case (result_src_q)
      SRC_ALU:  ResultW_o = alu_result_q;
      SRC_LOAD: ResultW_o = load_data_q;
      SRC_PC4:  ResultW_o = pc_plus4_q;
      default:  ResultW_o = '0;
    endcase
  end

  assign ValidW_o    = valid_q;
  assign RegWriteW_o = regwrite_q;
  assign RdW_o       = rd_q;
  assign MisalignW_o = misalign_q;

`ifdef MEMWB_RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  // Count real instructions entering W; flush and stall cycles do not count.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (!FlushW_i && !StallW_i && ValidM_i) begin
      retire_cnt_d = retire_cnt_q + CNT_W'(1);
    end
  end

  // Retire counter register, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign RetireCountW_o = retire_cnt_q;
`else
  assign RetireCountW_o = '0;
`endif

endmodule
